// File: rtl/pcm_dac_fifo.sv
// Stereo PCM FIFO feeding the SSM2603 DAC driver: primes to a backlog threshold before
// presenting samples, pops one L/R pair per driver request and counts underflows.
module pcm_dac_fifo #(
    parameter int LB_DATA_W = 32,
    parameter int LB_ADDR_W = 8,
    parameter int DEPTH     = 16,
    parameter int PTR_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 lb_wr_en,
    input  logic                 lb_rd_en,
    input  logic [LB_ADDR_W-1:0] lb_addr,
    input  logic [LB_DATA_W-1:0] lb_wr_data,
    output logic                 lb_wr_valid,
    output logic                 lb_rd_valid,
    output logic [LB_DATA_W-1:0] lb_rd_data,
    input  logic                 in_pcm_valid,
    output logic                 in_pcm_rdy,
    input  logic [31:0]          in_lpcm_data,
    input  logic [31:0]          in_rpcm_data,
    output logic                 dac_data_rdy,
    input  logic                 dac_pcm_nxt,
    output logic [31:0]          dac_lpcm_data,
    output logic [31:0]          dac_rpcm_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRIME  = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0] ZERO_C  = (PTR_W + 1)'(0);

    logic                 en_q, en_d;
    logic [PTR_W:0]       prime_th_q, prime_th_d;
    logic [15:0]          uflow_q, uflow_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       occ_q, occ_d;
    logic [63:0]          mem_q [DEPTH];
    logic [63:0]          mem_d [DEPTH];
    state_e               state_q, state_d;
    logic                 lb_wr_valid_q, lb_rd_valid_q;
    logic [LB_DATA_W-1:0] lb_rd_data_q, lb_rd_data_d;

    logic                 wr_ctrl_s, wr_uflow_s, wr_th_s, flush_s;
    logic                 full_s, empty_s, push_s, pop_s, drains_s, uflow_inc_s;
    logic [PTR_W:0]       eff_th_s;
    logic [LB_DATA_W-1:0] status_s;
    logic                 unused_wr_data_s;

    assign wr_ctrl_s  = lb_wr_en && (lb_addr == LB_ADDR_W'(0));
    assign wr_uflow_s = lb_wr_en && (lb_addr == LB_ADDR_W'(2));
    assign wr_th_s    = lb_wr_en && (lb_addr == LB_ADDR_W'(3));
    assign flush_s    = wr_ctrl_s && lb_wr_data[1];

    assign full_s     = (occ_q == DEPTH_C);
    assign empty_s    = (occ_q == ZERO_C);
    // Flush outranks both ends of the FIFO in the cycle it is written.
    assign in_pcm_rdy = en_q & ~full_s & ~flush_s;
    assign push_s     = in_pcm_valid & in_pcm_rdy;
    assign pop_s      = dac_pcm_nxt & ~empty_s & ~flush_s & en_q;
    assign drains_s   = pop_s & ~push_s & (occ_q == ONE_C);
    assign uflow_inc_s = (dac_pcm_nxt & empty_s) | ((state_q == ST_STREAM) & drains_s);

    assign dac_data_rdy = (state_q == ST_STREAM) & en_q & ~empty_s;
    assign {dac_lpcm_data, dac_rpcm_data} = mem_q[rd_ptr_q];

    assign lb_wr_valid = lb_wr_valid_q;
    assign lb_rd_valid = lb_rd_valid_q;
    assign lb_rd_data  = lb_rd_data_q;
    assign unused_wr_data_s = ^lb_wr_data[LB_DATA_W-1:PTR_W+1];

    // Effective prime threshold: clamp the programmed value into 1..DEPTH.
    always_comb begin
        if (prime_th_q == ZERO_C) begin
            eff_th_s = ONE_C;
        end else if (prime_th_q > DEPTH_C) begin
            eff_th_s = DEPTH_C;
        end else begin
            eff_th_s = prime_th_q;
        end
    end

    // Status word and local-bus read mux.
    always_comb begin
        status_s            = '0;
        status_s[PTR_W:0]   = occ_q;
        status_s[17:16]     = state_q;
        status_s[20]        = full_s;
        status_s[21]        = empty_s;
        lb_rd_data_d        = '0;
        if (lb_rd_en) begin
            case (lb_addr)
                LB_ADDR_W'(0): lb_rd_data_d = LB_DATA_W'(en_q);
                LB_ADDR_W'(1): lb_rd_data_d = status_s;
                LB_ADDR_W'(2): lb_rd_data_d = LB_DATA_W'(uflow_q);
                LB_ADDR_W'(3): lb_rd_data_d = LB_DATA_W'(prime_th_q);
                default:       lb_rd_data_d = LB_DATA_W'(32'hdeadbabe);
            endcase
        end else begin
            lb_rd_data_d = '0;
        end
    end

    // Control registers and saturating underflow counter.
    always_comb begin
        en_d       = en_q;
        prime_th_d = prime_th_q;
        uflow_d    = uflow_q;
        if (wr_ctrl_s) begin
            en_d = lb_wr_data[0];
        end else begin
            en_d = en_q;
        end
        if (wr_th_s) begin
            prime_th_d = lb_wr_data[PTR_W:0];
        end else begin
            prime_th_d = prime_th_q;
        end
        if (wr_uflow_s) begin
            uflow_d = 16'd0;
        end else if (uflow_inc_s && (uflow_q != 16'hffff)) begin
            uflow_d = uflow_q + 16'd1;
        end else begin
            uflow_d = uflow_q;
        end
    end

    // FIFO storage, pointers and occupancy; held empty while disabled.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (!en_q || flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = ZERO_C;
        end else begin
            if (push_s) begin
                mem_d[wr_ptr_q] = {in_lpcm_data, in_rpcm_data};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   occ_d = occ_q + ONE_C;
                2'b01:   occ_d = occ_q - ONE_C;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Playback state: wait for backlog, stream until the FIFO runs dry.
    always_comb begin
        state_d = state_q;
        if (!en_q) begin
            state_d = ST_IDLE;
        end else if (flush_s) begin
            state_d = lb_wr_data[0] ? ST_PRIME : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_PRIME;
                ST_PRIME:  state_d = (occ_q >= eff_th_s) ? ST_STREAM : ST_PRIME;
                ST_STREAM: state_d = (empty_s || drains_s) ? ST_PRIME : ST_STREAM;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q          <= 1'b0;
            prime_th_q    <= ONE_C;
            uflow_q       <= 16'd0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            occ_q         <= ZERO_C;
            state_q       <= ST_IDLE;
            lb_wr_valid_q <= 1'b0;
            lb_rd_valid_q <= 1'b0;
            lb_rd_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else begin
            en_q          <= en_d;
            prime_th_q    <= prime_th_d;
            uflow_q       <= uflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            occ_q         <= occ_d;
            state_q       <= state_d;
            lb_wr_valid_q <= lb_wr_en;
            lb_rd_valid_q <= lb_rd_en;
            lb_rd_data_q  <= lb_rd_data_d;
            mem_q         <= mem_d;
        end
    end

endmodule

// File: tb/tb_pcm_dac_fifo.sv
// Directed and randomized bench for pcm_dac_fifo against a queue-based reference model.
module tb_pcm_dac_fifo;
    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lb_wr_en = 1'b0, lb_rd_en = 1'b0;
    logic [7:0]  lb_addr = 8'd0;
    logic [31:0] lb_wr_data = 32'd0;
    logic        lb_wr_valid, lb_rd_valid;
    logic [31:0] lb_rd_data;
    logic        in_pcm_valid = 1'b0, in_pcm_rdy;
    logic [31:0] in_lpcm_data = 32'd0, in_rpcm_data = 32'd0;
    logic        dac_data_rdy, dac_pcm_nxt = 1'b0;
    logic [31:0] dac_lpcm_data, dac_rpcm_data;

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a queue of {L,R}, plus control/status values.
    logic [63:0] mq[$];
    int m_en = 0, m_th = 1, m_uflow = 0, m_st = 0;

    pcm_dac_fifo #(.LB_DATA_W(32), .LB_ADDR_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
        .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
        .in_pcm_valid(in_pcm_valid), .in_pcm_rdy(in_pcm_rdy),
        .in_lpcm_data(in_lpcm_data), .in_rpcm_data(in_rpcm_data),
        .dac_data_rdy(dac_data_rdy), .dac_pcm_nxt(dac_pcm_nxt),
        .dac_lpcm_data(dac_lpcm_data), .dac_rpcm_data(dac_rpcm_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_th();
        if (m_th == 0) return 1;
        if (m_th > DEPTH) return DEPTH;
        return m_th;
    endfunction

    // One clock: check outputs against the model, advance the model, check LB acks.
    task automatic tick();
        logic [63:0] exp_rd;
        bit flush, full, empty, rdy, push, pop, inc, rd_s, wr_s;
        int sz, nst;
        #1;
        sz    = mq.size();
        full  = (sz == DEPTH);
        empty = (sz == 0);
        flush = lb_wr_en && (lb_addr == 8'd0) && lb_wr_data[1];
        rdy   = (m_en != 0) && !full && !flush;
        push  = in_pcm_valid && rdy;
        pop   = dac_pcm_nxt && !empty && !flush && (m_en != 0);
        chk("in_pcm_rdy", in_pcm_rdy, rdy);
        chk("dac_data_rdy", dac_data_rdy, (m_st == 2) && (m_en != 0) && !empty);
        if (!empty) chk("head", {dac_lpcm_data, dac_rpcm_data}, mq[0]);
        case (int'(lb_addr))
            0: exp_rd = 64'(m_en);
            1: exp_rd = 64'(sz) | (64'(m_st) << 16) | (64'(full) << 20) | (64'(empty) << 21);
            2: exp_rd = 64'(m_uflow);
            3: exp_rd = 64'(m_th);
            default: exp_rd = 64'hdeadbabe;
        endcase
        inc = (dac_pcm_nxt && empty) || ((m_st == 2) && pop && !push && (sz == 1));
        if (m_en == 0) nst = 0;
        else if (flush) nst = lb_wr_data[0] ? 1 : 0;
        else if (m_st == 0) nst = 1;
        else if (m_st == 1) nst = (sz >= eff_th()) ? 2 : 1;
        else nst = (empty || ((sz == 1) && pop && !push)) ? 1 : 2;
        if ((m_en == 0) || flush) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back({in_lpcm_data, in_rpcm_data});
        end
        if (lb_wr_en && (lb_addr == 8'd0)) m_en = int'(lb_wr_data[0]);
        if (lb_wr_en && (lb_addr == 8'd3)) m_th = int'(lb_wr_data[PTR_W:0]);
        if (lb_wr_en && (lb_addr == 8'd2)) m_uflow = 0;
        else if (inc && (m_uflow < 65535)) m_uflow++;
        m_st = nst;
        rd_s = lb_rd_en;
        wr_s = lb_wr_en;
        @(posedge clk);
        #1;
        chk("lb_wr_valid", lb_wr_valid, wr_s);
        chk("lb_rd_valid", lb_rd_valid, rd_s);
        if (rd_s) chk("lb_rd_data", lb_rd_data, exp_rd);
    endtask

    task automatic lb_wr(input int a, input logic [31:0] d);
        lb_wr_en = 1'b1; lb_addr = 8'(a); lb_wr_data = d;
        tick();
        lb_wr_en = 1'b0;
    endtask

    task automatic lb_rd(input int a);
        lb_rd_en = 1'b1; lb_addr = 8'(a);
        tick();
        lb_rd_en = 1'b0;
    endtask

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        in_pcm_valid = 1'b1; in_lpcm_data = l; in_rpcm_data = r;
        tick();
        in_pcm_valid = 1'b0;
    endtask

    task automatic pulse_nxt();
        dac_pcm_nxt = 1'b1;
        tick();
        dac_pcm_nxt = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_pcm_rdy", in_pcm_rdy, 0);
        chk("rst_dac_data_rdy", dac_data_rdy, 0);
        chk("rst_lb_rd_valid", lb_rd_valid, 0);
        chk("rst_lb_wr_valid", lb_wr_valid, 0);
        chk("rst_lb_rd_data", lb_rd_data, 0);
        chk("rst_dac_data", {dac_lpcm_data, dac_rpcm_data}, 0);

        // Reset register values and unmapped address.
        lb_rd(3);
        chk("rst_prime_th", lb_rd_data, 32'd1);
        lb_rd(5);
        chk("unmapped_rd", lb_rd_data, 32'hdeadbabe);
        chk("unmapped_rd_valid", lb_rd_valid, 1);
        lb_rd(1);
        chk("rst_status", lb_rd_data, 32'h0020_0000);
        tick();

        // Prime threshold of 4.
        lb_wr(3, 32'd4);
        lb_wr(0, 32'd1);
        for (int i = 1; i <= 3; i++) push(32'(i), 32'(-i));
        tick();
        chk("prime_not_rdy", dac_data_rdy, 0);
        push(32'd4, 32'(-4));
        tick();
        chk("prime_rdy", dac_data_rdy, 1);
        chk("prime_head", {dac_lpcm_data, dac_rpcm_data}, {32'd1, 32'hffff_ffff});

        // Fill to full, then simultaneous push and pop.
        lb_wr(0, 32'd3);
        for (int i = 0; i < 17; i++) push(32'(100 + i), ~32'(i));
        chk("full_rdy_low", in_pcm_rdy, 0);
        lb_rd(1);
        chk("full_status", lb_rd_data, 32'h0012_0010);
        in_pcm_valid = 1'b1; in_lpcm_data = 32'h55; in_rpcm_data = 32'h66; dac_pcm_nxt = 1'b1;
        tick();
        in_pcm_valid = 1'b0; dac_pcm_nxt = 1'b0;
        lb_rd(1);
        chk("full_pushpop_status", lb_rd_data, 32'h0002_000f);
        chk("full_pushpop_head", {dac_lpcm_data, dac_rpcm_data}, {32'd101, ~32'd1});

        // Underflow counting and clearing.
        lb_wr(0, 32'd3);
        lb_wr(3, 32'd1);
        lb_wr(2, 32'd0);
        push(32'd7, 32'd8);
        tick();
        chk("uf_stream_rdy", dac_data_rdy, 1);
        pulse_nxt();
        lb_rd(2);
        chk("uf_count1", lb_rd_data, 32'd1);
        lb_rd(1);
        chk("uf_status_prime", lb_rd_data, 32'h0021_0000);
        pulse_nxt();
        lb_rd(2);
        chk("uf_count2", lb_rd_data, 32'd2);
        lb_wr(2, 32'hffff_ffff);
        lb_rd(2);
        chk("uf_clear", lb_rd_data, 32'd0);

        // Randomized interleaved streaming across pointer wrap.
        for (int c = 0; c < 240; c++) begin
            in_pcm_valid = 1'($urandom_range(0, 1));
            in_lpcm_data = $urandom;
            in_rpcm_data = $urandom;
            dac_pcm_nxt  = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_pcm_valid = 1'b0;
        for (int c = 0; c < DEPTH + 2; c++) pulse_nxt();
        lb_rd(1);
        chk("wrap_drained_empty", lb_rd_data[21], 1);

        // Flush colliding with a push.
        lb_wr(2, 32'd0);
        for (int i = 0; i < 8; i++) push(32'(200 + i), 32'(300 + i));
        tick();
        lb_wr_en = 1'b1; lb_addr = 8'd0; lb_wr_data = 32'd3;
        in_pcm_valid = 1'b1; in_lpcm_data = 32'haa; in_rpcm_data = 32'hbb;
        tick();
        lb_wr_en = 1'b0; in_pcm_valid = 1'b0;
        chk("flush_dac_rdy", dac_data_rdy, 0);
        lb_rd(1);
        chk("flush_status", lb_rd_data, 32'h0021_0000);
        lb_wr(0, 32'd0);
        tick();
        lb_rd(1);
        chk("disable_status", lb_rd_data, 32'h0020_0000);
        chk("disable_rdy", in_pcm_rdy, 0);

        // Threshold clamping: 0 behaves as 1, oversize behaves as DEPTH.
        lb_wr(0, 32'd1);
        lb_wr(3, 32'd0);
        push(32'd9, 32'd10);
        tick();
        chk("th0_rdy", dac_data_rdy, 1);
        lb_wr(0, 32'd3);
        lb_wr(3, 32'd31);
        for (int i = 0; i < DEPTH - 1; i++) push(32'(i), 32'(i));
        tick();
        chk("th_big_not_rdy", dac_data_rdy, 0);
        push(32'd77, 32'd88);
        tick();
        chk("th_big_rdy", dac_data_rdy, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
